// File: rtl/cci_rd_arbiter.sv
// Round-robin arbiter for N_REQ read requesters onto FIU c0, with mdata-tagged response routing.
// Grants are combinational and requests/responses reach the outputs one cycle later; almfull, drain and per-requester credits withhold grants.
module cci_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int MAX_OUT = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    c0_almfull,
  output logic                    tx_valid,
  output logic [ADDR_W-1:0]       tx_addr,
  output logic [15:0]             tx_mdata,
  input  logic                    rx_valid,
  input  logic [15:0]             rx_mdata,
  input  logic [511:0]            rx_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [511:0]            rsp_data,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic                    err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] MaxOut = 8'(MAX_OUT);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] DRAINED = 2'd2;

  logic [1:0]       state;
  logic [7:0]       cnt [N_REQ];
  logic [IW-1:0]    lastGrant;
  logic [IW-1:0]    gntIdx;
  logic             gntAny;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] xfer;
  logic [N_REQ-1:0] rspHit;
  logic             rxTagOk;
  logic             rspAccept;
  logic             allIdle;

  // Unused high mdata bits must be zero or the tag is treated as corrupt.
  assign rxTagOk = (rx_mdata[15:IW] == '0);

  always_comb begin
    elig    = '0;
    rspHit  = '0;
    allIdle = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]   = (state == RUN) && req_valid[i] && !c0_almfull && (cnt[i] < MaxOut);
      rspHit[i] = rx_valid && rxTagOk && (rx_mdata[IW-1:0] == IW'(i)) && (cnt[i] != 8'd0);
      if (cnt[i] != 8'd0) allIdle = 1'b0;
    end
  end

  assign rspAccept = |rspHit;

  always_comb begin
    int cand;
    cand   = 0;
    gntIdx = '0;
    gntAny = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(lastGrant) + k) % N_REQ;
      if (!gntAny && elig[cand]) begin
        gntAny = 1'b1;
        gntIdx = IW'(cand);
      end
    end
  end

  assign req_ready  = (reset_n && gntAny) ? (N_REQ'(1) << gntIdx) : '0;
  assign xfer       = req_valid & req_ready;
  assign drain_done = (state == DRAINED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      lastGrant <= IW'(N_REQ - 1);
      tx_valid  <= 1'b0;
      tx_addr   <= '0;
      tx_mdata  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= 8'd0;
    end else begin
      case (state)
        RUN:     if (drain_req) state <= DRAIN;
        DRAIN:   if (!drain_req) state <= RUN;
                 else if (allIdle) state <= DRAINED;
        DRAINED: if (!drain_req) state <= RUN;
        default: state <= RUN;
      endcase

      tx_valid <= |xfer;
      if (|xfer) begin
        lastGrant <= gntIdx;
        tx_addr   <= req_addr[gntIdx*ADDR_W +: ADDR_W];
        tx_mdata  <= {{(16-IW){1'b0}}, gntIdx};
      end

      rsp_valid <= rspHit;
      if (rspAccept) rsp_data <= rx_data;
      if (rx_valid && !rspAccept) err <= 1'b1;

      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= cnt[i] + {7'd0, xfer[i]} - {7'd0, rspHit[i]};
    end
  end

endmodule

// File: tb/tb_cci_rd_arbiter.sv
// Directed bench for cci_rd_arbiter (N_REQ=4, MAX_OUT=2): inputs change 1ns after posedge, outputs sampled at negedge.
module tb_cci_rd_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 42;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0_almfull;
  logic                    tx_valid;
  logic [ADDR_W-1:0]       tx_addr;
  logic [15:0]             tx_mdata;
  logic                    rx_valid;
  logic [15:0]             rx_mdata;
  logic [511:0]            rx_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [511:0]            rsp_data;
  logic                    drain_req;
  logic                    drain_done;
  logic                    err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cci_rd_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .MAX_OUT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .c0_almfull(c0_almfull),
    .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata),
    .rx_valid(rx_valid), .rx_mdata(rx_mdata), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain_req(drain_req), .drain_done(drain_done), .err(err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addrOf(input int i);
    return ADDR_W'(64'h1000 + 64'(i) * 64'h40);
  endfunction

  // Leaves the bench 1ns after the posedge that releases reset.
  task automatic doReset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    req_valid = '0; c0_almfull = 1'b0; rx_valid = 1'b0;
    rx_mdata = '0; rx_data = '0; drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic respond(input logic [15:0] tag, input logic [511:0] data);
    rx_valid = 1'b1; rx_mdata = tag; rx_data = data;
    nextCycle();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] d1, d2, d3;
    d1 = {16{32'hA5A5_0001}};
    d2 = {16{32'h5A5A_0002}};
    d3 = {16{32'hC3C3_0003}};
    for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addrOf(i);
    reset_n = 1'b0; req_valid = 4'hF; c0_almfull = 1'b0; rx_valid = 1'b0;
    rx_mdata = '0; rx_data = '0; drain_req = 1'b0;

    // Reset state, with requests pending to prove req_ready is forced low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 512'(req_ready), 512'(4'b0000));
    check("rst_txv", 512'(tx_valid), 512'(0));
    check("rst_rspv", 512'(rsp_valid), 512'(0));
    check("rst_rspd", rsp_data, 512'(0));
    check("rst_err", 512'(err), 512'(0));
    check("rst_done", 512'(drain_done), 512'(0));

    // Round-robin fairness; MAX_OUT=2 lets every requester take exactly two grants.
    doReset();
    req_valid = 4'hF;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", n), 512'(req_ready), 512'(4'b0001 << (n % 4)));
      if (n > 0) begin
        check($sformatf("rr_txv%0d", n), 512'(tx_valid), 512'(1));
        check($sformatf("rr_mdata%0d", n), 512'(tx_mdata), 512'((n - 1) % 4));
        check($sformatf("rr_addr%0d", n), 512'(tx_addr), 512'(addrOf((n - 1) % 4)));
      end
      nextCycle();
    end
    @(negedge clk);
    check("rr_credit_out", 512'(req_ready), 512'(0));
    check("rr_last_mdata", 512'(tx_mdata), 512'(3));
    nextCycle();
    @(negedge clk);
    check("rr_idle_txv", 512'(tx_valid), 512'(0));

    // Backpressure from almost-full.
    doReset();
    req_valid = 4'hF;
    @(negedge clk);
    check("bp_first", 512'(req_ready), 512'(4'b0001));
    nextCycle();
    c0_almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_ready%0d", k), 512'(req_ready), 512'(0));
      if (k > 0) check($sformatf("bp_txv%0d", k), 512'(tx_valid), 512'(0));
      nextCycle();
    end
    c0_almfull = 1'b0;
    @(negedge clk);
    check("bp_resume", 512'(req_ready), 512'(4'b0010));
    nextCycle();
    req_valid = '0;

    // Credit limit for requester 1, then a response frees one credit.
    doReset();
    req_valid = 4'b0010;
    @(negedge clk); check("cr_g1", 512'(req_ready), 512'(4'b0010));
    nextCycle();
    @(negedge clk); check("cr_g2", 512'(req_ready), 512'(4'b0010));
    nextCycle();
    @(negedge clk); check("cr_block", 512'(req_ready), 512'(0));
    nextCycle();
    @(negedge clk); check("cr_block2", 512'(req_ready), 512'(0));
    respond(16'd1, d1);
    @(negedge clk);
    check("cr_rspv", 512'(rsp_valid), 512'(4'b0010));
    check("cr_rspd", rsp_data, d1);
    check("cr_g3", 512'(req_ready), 512'(4'b0010));
    nextCycle();
    @(negedge clk); check("cr_block3", 512'(req_ready), 512'(0));
    req_valid = '0;

    // Response for requester 2 in the same cycle as a grant to requester 2.
    doReset();
    req_valid = 4'b0100;
    nextCycle();
    rx_valid = 1'b1; rx_mdata = 16'd2; rx_data = d2;
    @(negedge clk); check("sim_grant", 512'(req_ready), 512'(4'b0100));
    nextCycle();
    rx_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    check("sim_rspv", 512'(rsp_valid), 512'(4'b0100));
    check("sim_rspd", rsp_data, d2);
    check("sim_txm", 512'(tx_mdata), 512'(2));
    check("sim_err", 512'(err), 512'(0));
    nextCycle();
    req_valid = 4'b0100;
    @(negedge clk);
    check("sim_hold_rspv", 512'(rsp_valid), 512'(0));
    check("sim_hold_rspd", rsp_data, d2);
    check("sim_cnt1", 512'(req_ready), 512'(4'b0100));
    nextCycle();
    @(negedge clk); check("sim_cnt2", 512'(req_ready), 512'(0));
    req_valid = '0;

    // Drain with cnt = {1,0,2,0}.
    doReset();
    req_valid = 4'b0101;
    @(negedge clk); check("dr_g0", 512'(req_ready), 512'(4'b0001));
    nextCycle();
    @(negedge clk); check("dr_g2", 512'(req_ready), 512'(4'b0100));
    nextCycle();
    req_valid = 4'b0100;
    nextCycle();
    req_valid = '0; drain_req = 1'b1;
    nextCycle();
    req_valid = 4'hF;
    @(negedge clk);
    check("dr_nogrant", 512'(req_ready), 512'(0));
    check("dr_notdone", 512'(drain_done), 512'(0));
    respond(16'd0, d1);
    respond(16'd2, d2);
    @(negedge clk); check("dr_wait", 512'(drain_done), 512'(0));
    respond(16'd2, d3);
    @(negedge clk);
    check("dr_rspv", 512'(rsp_valid), 512'(4'b0100));
    check("dr_pending", 512'(drain_done), 512'(0));
    nextCycle();
    @(negedge clk);
    check("dr_done", 512'(drain_done), 512'(1));
    check("dr_done_nogrant", 512'(req_ready), 512'(0));
    check("dr_err", 512'(err), 512'(0));
    nextCycle();
    drain_req = 1'b0;
    @(negedge clk); check("dr_still", 512'(drain_done), 512'(1));
    nextCycle();
    @(negedge clk);
    check("dr_run", 512'(drain_done), 512'(0));
    check("dr_resume", 512'(req_ready), 512'(4'b1000));
    req_valid = '0;

    // Bad tag: mdata 0x0005 sets sticky err until reset.
    doReset();
    respond(16'h0005, d1);
    @(negedge clk);
    check("er_set", 512'(err), 512'(1));
    check("er_rspv", 512'(rsp_valid), 512'(0));
    repeat (3) nextCycle();
    @(negedge clk); check("er_sticky", 512'(err), 512'(1));
    doReset();
    @(negedge clk); check("er_clear", 512'(err), 512'(0));

    // Mid-operation reset discards the outstanding read; its late response is an error.
    req_valid = 4'b0010;
    nextCycle();
    req_valid = '0;
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    respond(16'd1, d1);
    @(negedge clk);
    check("mr_err", 512'(err), 512'(1));
    check("mr_rspv", 512'(rsp_valid), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
